button_onehot_latch: RTL and testbench

- Upstream front-end for the 4-to-2 encoder.
- Takes four raw, asynchronous button lines, then synchronises, debounces and edge-detects each one.
- Latches exactly one press as a one-hot code on onehot[3:0], which drives the encoder's D3..D0 inputs.
- Holds the code stable until the consumer acknowledges, then waits for all buttons to be released before it accepts the next press.

---
 rtl/button_pkg.sv | 31 +++
 rtl/debounce_bit.sv | 45 ++++
 rtl/button_onehot_latch.sv | 93 +++++++++
 tb/tb_button_onehot_latch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the button one-hot latch front-end.
package button_pkg;

    localparam int N_LINES                 = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Highest set bit wins: D3 has top priority over D0.
    function automatic logic [N_LINES-1:0] pick_highest(input logic [N_LINES-1:0] req);
        logic [N_LINES-1:0] grant;
        grant = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        return grant;
    endfunction

    // True when two or more request bits are set.
    function automatic logic more_than_one(input logic [N_LINES-1:0] req);
        return |(req & (req - 1'b1));
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button line: two-flop synchroniser, debounce counter and rising-press detect.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic deb,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          update;

    // The debounced level flips on the cycle the counter has seen enough disagreeing samples.
    assign update = (s2 != deb) && (cnt == CNT_LAST);
    assign press  = update & s2;

    // Synchroniser, disagreement counter and debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (update) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_onehot_latch.sv
// Button front-end for the 4-to-2 encoder: latches one debounced press as a one-hot code.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a debounced press; outputs cleared
// HOLD     | code captured and presented; waiting for ack
// WAIT_REL | code dropped; waiting for every debounced line to go low
module button_onehot_latch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] btn,
    input  logic               ack,
    output logic [N_LINES-1:0] onehot,
    output logic               valid,
    output logic               multi_err
);

    logic [N_LINES-1:0] deb;
    logic [N_LINES-1:0] press;

    state_t             state;
    state_t             state_nx;
    logic [N_LINES-1:0] onehot_nx;
    logic               valid_nx;
    logic               multi_err_nx;

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .deb  (deb[i]),
            .press(press[i])
        );
    end

    // Next-state and next-output decode; the code is frozen outside IDLE.
    always_comb begin
        state_nx     = state;
        onehot_nx    = onehot;
        valid_nx     = valid;
        multi_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (|press) begin
                    onehot_nx    = pick_highest(press);
                    valid_nx     = 1'b1;
                    multi_err_nx = more_than_one(press);
                    state_nx     = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    onehot_nx = '0;
                    valid_nx  = 1'b0;
                    state_nx  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (deb == '0) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                onehot_nx = '0;
                valid_nx  = 1'b0;
                state_nx  = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            onehot    <= '0;
            valid     <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_nx;
            onehot    <= onehot_nx;
            valid     <= valid_nx;
            multi_err <= multi_err_nx;
        end
    end

endmodule

// File: tb/tb_button_onehot_latch.sv
// Scoreboard bench for button_onehot_latch with directed press sequences.
module tb_button_onehot_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic       ack;
    logic [3:0] btn;
    logic [3:0] onehot;
    logic       valid;
    logic       multi_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] oh;
        logic       me;
        logic [1:0] enc;
        int         at;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic prev_valid = 1'b0;
    bit   mon_en     = 1'b0;

    button_onehot_latch #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .ack      (ack),
        .onehot   (onehot),
        .valid    (valid),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 4-to-2 encoder model: A1 = D3|D2, A0 = D3|D1.
    function automatic logic [1:0] enc_of(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    // Monitor: every cycle checks the invariant; on each rising valid pops one expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((valid !== (onehot != 4'd0)) || ((onehot & (onehot - 4'd1)) != 4'd0)) begin
                errors++;
                $display("FAIL invariant cyc=%0d onehot=%b valid=%b", cyc, onehot, valid);
            end
            if (valid && !prev_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_capture cyc=%0d onehot=%b expected no capture", cyc, onehot);
                end else begin
                    e = sb.pop_front();
                    if (onehot !== e.oh || multi_err !== e.me || enc_of(onehot) !== e.enc || cyc != e.at) begin
                        errors++;
                        $display("FAIL %s: got onehot=%b multi_err=%b enc=%b cyc=%0d, expected onehot=%b multi_err=%b enc=%b cyc=%0d",
                                 e.name, onehot, multi_err, enc_of(onehot), cyc, e.oh, e.me, e.enc, e.at);
                    end
                end
            end else begin
                checks++;
                if (multi_err !== 1'b0) begin
                    errors++;
                    $display("FAIL multi_err_stray cyc=%0d got %b expected 0", cyc, multi_err);
                end
            end
        end
        prev_valid = valid;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the negedge where btn was just changed; capture lands 6 edges later.
    task automatic expect_capture(input logic [3:0] oh, input logic me, input logic [1:0] enc, input string nm);
        exp_t x;
        x.oh   = oh;
        x.me   = me;
        x.enc  = enc;
        x.at   = cyc + 6;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (valid === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: valid=%b expected 1 within 20 cycles", nm, valid);
        end
    endtask

    task automatic check_outputs(input string nm, input logic [3:0] oh, input logic v);
        checks++;
        if (onehot !== oh || valid !== v || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got onehot=%b valid=%b multi_err=%b, expected onehot=%b valid=%b multi_err=0",
                     nm, onehot, valid, multi_err, oh, v);
        end
    endtask

    task automatic do_ack(input string nm);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_outputs(nm, 4'b0000, 1'b0);
    endtask

    task automatic release_all();
        btn = 4'b0000;
        step(12);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ack = 1'b0;
        btn = 4'b0000;
        step(3);
        check_outputs("reset_state", 4'b0000, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Single press on D0.
        btn = 4'b0001;
        expect_capture(4'b0001, 1'b0, 2'b00, "single_d0");
        wait_valid("single_d0");
        do_ack("ack_single_d0");
        release_all();

        // 3-cycle glitch on D1 must be rejected, 5-cycle press accepted.
        btn = 4'b0010;
        step(3);
        btn = 4'b0000;
        step(12);
        check_outputs("glitch_rejected", 4'b0000, 1'b0);
        btn = 4'b0010;
        expect_capture(4'b0010, 1'b0, 2'b01, "press_d1");
        step(5);
        btn = 4'b0000;
        wait_valid("press_d1");
        do_ack("ack_d1");
        release_all();

        // Simultaneous D3 and D1.
        btn = 4'b1010;
        expect_capture(4'b1000, 1'b1, 2'b11, "simultaneous");
        wait_valid("simultaneous");
        step(2);
        check_outputs("simultaneous_hold", 4'b1000, 1'b1);
        do_ack("ack_simultaneous");
        release_all();

        // Hold, ignore later press, ack, hold-down, release, new press.
        btn = 4'b0100;
        expect_capture(4'b0100, 1'b0, 2'b10, "press_d2");
        wait_valid("press_d2");
        btn = 4'b0101;
        step(10);
        check_outputs("hold_ignores_d0", 4'b0100, 1'b1);
        do_ack("ack_d2");
        step(20);
        check_outputs("wait_release", 4'b0000, 1'b0);
        release_all();
        btn = 4'b0001;
        expect_capture(4'b0001, 1'b0, 2'b00, "after_release_d0");
        wait_valid("after_release_d0");
        do_ack("ack_after_release");
        release_all();

        // Reset mid-HOLD with D3 held through reset.
        btn = 4'b1000;
        expect_capture(4'b1000, 1'b0, 2'b11, "press_d3");
        wait_valid("press_d3");
        rst = 1'b1;
        step(2);
        check_outputs("reset_mid_hold", 4'b0000, 1'b0);
        rst = 1'b0;
        expect_capture(4'b1000, 1'b0, 2'b11, "d3_after_reset");
        wait_valid("d3_after_reset");
        do_ack("ack_d3_after_reset");
        release_all();

        // ack in IDLE is ignored; a following press still captures.
        ack = 1'b1;
        step(3);
        ack = 1'b0;
        check_outputs("ack_in_idle", 4'b0000, 1'b0);
        btn = 4'b0010;
        expect_capture(4'b0010, 1'b0, 2'b01, "press_after_idle_ack");
        wait_valid("press_after_idle_ack");
        do_ack("ack_final");
        release_all();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
